// File: rtl/swan_pkg.sv
// Shared SWAN definitions: default block width, half-block/column width
// derivations, and the state type of the rho column-mixing controller.
package swan_pkg;

  // Default cipher block width in bits; must be a multiple of 8.
  localparam int BLOCK_SIZE_DEF = 64;

  // Half-block width handled by one rho instance.
  function automatic int side_size(input int block_size);
    return block_size / 2;
  endfunction

  // A half-block is four columns.
  function automatic int column_size(input int block_size);
    return block_size / 8;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } rho_state_t;

endpackage : swan_pkg

// File: rtl/serial_rho_if.sv
// Valid/ready bus carrying a half-block into rho and the mixed result out.
// The slave modport is the rho block's view; master is the producer/consumer.
import swan_pkg::*;

interface serial_rho_if #(
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF
);
  localparam int SIDE_SIZE = side_size(BLOCK_SIZE);

  logic                 in_valid;
  logic                 in_ready;
  logic [0:SIDE_SIZE-1] x;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:SIDE_SIZE-1] y;

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y
  );

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );
endinterface : serial_rho_if

// File: rtl/rho_column_xor.sv
// One column-wide two-input XOR: the whole arithmetic of rho. The serial
// build shares a single copy between accumulation and apply.
module rho_column_xor #(
  parameter int COLUMN_SIZE = 8
) (
  input  logic [0:COLUMN_SIZE-1] a_i,
  input  logic [0:COLUMN_SIZE-1] b_i,
  output logic [0:COLUMN_SIZE-1] y_o
);

  assign y_o = a_i ^ b_i;

endmodule : rho_column_xor

// File: rtl/serial_rho.sv
// SWAN rho layer: each output column is the XOR of the other three input
// columns, computed as y_c = x_c ^ (x0^x1^x2^x3).
// Default build walks one column per clock (4 accumulate + 4 apply cycles).
// Defining RHO_PARALLEL_EN replaces both walks with a single-cycle,
// four-column combinational computation; ports and function are unchanged.
import swan_pkg::*;

module serial_rho #(
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF
) (
  input logic         clk,
  input logic         rst,
  serial_rho_if.slave bus
);

  localparam int SIDE_SIZE   = side_size(BLOCK_SIZE);
  localparam int COLUMN_SIZE = column_size(BLOCK_SIZE);

  rho_state_t           state_q, state_d;
  logic [0:SIDE_SIZE-1] x_q;
  logic [0:SIDE_SIZE-1] y_q;

`ifdef RHO_PARALLEL_EN

  logic [0:COLUMN_SIZE-1] p_par;
  logic [0:SIDE_SIZE-1]   y_par;

  // Column parity of the captured half-block.
  assign p_par = x_q[0*COLUMN_SIZE +: COLUMN_SIZE] ^ x_q[1*COLUMN_SIZE +: COLUMN_SIZE]
               ^ x_q[2*COLUMN_SIZE +: COLUMN_SIZE] ^ x_q[3*COLUMN_SIZE +: COLUMN_SIZE];

  for (genvar c = 0; c < 4; c++) begin : g_col
    rho_column_xor #(.COLUMN_SIZE(COLUMN_SIZE)) u_xor (
      .a_i (x_q[c*COLUMN_SIZE +: COLUMN_SIZE]),
      .b_i (p_par),
      .y_o (y_par[c*COLUMN_SIZE +: COLUMN_SIZE])
    );
  end

  // Capture x on acceptance; write all four result columns in APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid) x_q <= bus.x;
        APPLY:   y_q <= y_par;
        default: ;
      endcase
    end
  end

`else

  logic [1:0]             col_q;
  logic [0:COLUMN_SIZE-1] p_q;
  logic [0:COLUMN_SIZE-1] x_col;
  logic [0:COLUMN_SIZE-1] xor_out;

  // Current column of the captured half-block, selected by the counter.
  assign x_col = x_q[int'(col_q)*COLUMN_SIZE +: COLUMN_SIZE];

  // Single shared XOR: parity update in ACCUM, result column in APPLY.
  rho_column_xor #(.COLUMN_SIZE(COLUMN_SIZE)) u_xor (
    .a_i (x_col),
    .b_i (p_q),
    .y_o (xor_out)
  );

  // Capture x, accumulate the column parity, then emit one column per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the control, so an
      // aborted operation leaves y at zero instead of a half-written value.
      x_q   <= '0;
      p_q   <= '0;
      y_q   <= '0;
      col_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q   <= bus.x;
            p_q   <= '0;
            col_q <= 2'd0;
          end
        end
        ACCUM: begin
          p_q   <= xor_out;
          col_q <= col_q + 2'd1;
        end
        APPLY: begin
          y_q[int'(col_q)*COLUMN_SIZE +: COLUMN_SIZE] <= xor_out;
          col_q <= col_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of every other, independent of process ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d
    // unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
`ifdef RHO_PARALLEL_EN
      IDLE:  if (bus.in_valid) state_d = APPLY;
      ACCUM: state_d = APPLY;
      APPLY: state_d = DONE;
`else
      IDLE:  if (bus.in_valid) state_d = ACCUM;
      ACCUM: if (col_q == 2'd3) state_d = APPLY;
      APPLY: if (col_q == 2'd3) state_d = DONE;
`endif
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.y = y_q;

endmodule : serial_rho

// File: tb/tb_serial_rho.sv
// Bench for serial_rho (32-bit half-block). Expected results come from an
// independent column model, queued on acceptance and compared on output.
module tb_serial_rho;

`ifdef RHO_PARALLEL_EN
  localparam int LAT    = 1;
  localparam int PERIOD = 3;
`else
  localparam int LAT    = 8;
  localparam int PERIOD = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_rho_if bus_if ();

  serial_rho dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [31:0] exp_q[$];

  // Reference: output column c is the XOR of the three other input columns.
  function automatic logic [31:0] rho_model(input logic [31:0] v);
    logic [7:0]  col[4];
    logic [7:0]  acc;
    logic [31:0] r;
    for (int c = 0; c < 4; c++) col[c] = v[31-8*c -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) if (j != c) acc = acc ^ col[j];
      r[31-8*c -: 8] = acc;
    end
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.in_valid && bus_if.in_ready) exp_q.push_back(rho_model(bus_if.x));
      if (bus_if.out_valid && bus_if.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: y=%h with no pending input", bus_if.y);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          n_out++;
          if (bus_if.y !== e) begin
            errors++;
            $display("FAIL scoreboard_y: got %h expected %h", bus_if.y, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!bus_if.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus_if.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", bus_if.in_ready, n);
    end
  endtask

  // Present v for exactly one accepted edge, then scramble x.
  task automatic send(input logic [31:0] v);
    wait_in_ready();
    bus_if.in_valid = 1'b1;
    bus_if.x        = v;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.x        = ~v;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!bus_if.out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus_if.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, expected 1", bus_if.out_valid, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.x         = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
    end
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.y !== 32'h0) begin
      errors++;
      $display("FAIL reset_y: got %h expected 00000000", bus_if.y);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vin [6] = '{32'hc8110af6, 32'hed342fd3, 32'h00000000,
                             32'hffffffff, 32'h01000000, 32'h000000ff};
    logic [31:0] vout[6] = '{32'hed342fd3, 32'hc8110af6, 32'h00000000,
                             32'hffffffff, 32'h00010101, 32'hffffff00};
    int n;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vin[i]);
      wait_out_valid(n);
      checks++;
      if (n !== LAT) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d edges expected %0d", i, n, LAT);
      end
      checks++;
      if (bus_if.y !== vout[i]) begin
        errors++;
        $display("FAIL vector_y[%0d]: x=%h got %h expected %h", i, vin[i], bus_if.y, vout[i]);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v = 32'h12345678;
    logic [31:0] e;
    int n;
    e = rho_model(v);
    bus_if.out_ready = 1'b0;
    send(v);
    wait_out_valid(n);
    // in_valid outside IDLE must be ignored.
    bus_if.in_valid = 1'b1;
    bus_if.x        = 32'hdeadbeef;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.y !== e) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b y=%h expected 1 0 %h",
                 i, bus_if.out_valid, bus_if.in_ready, bus_if.y, e);
      end
      tick();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b expected 1 0",
               bus_if.in_ready, bus_if.out_valid);
    end
    checks++;
    if (bus_if.y !== e) begin
      errors++;
      $display("FAIL y_retained: got %h expected %h", bus_if.y, e);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int  n;
    bit  flagged = 1'b0;
    bus_if.out_ready = 1'b1;
    send(32'hed342fd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.y !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_state: in_ready=%b out_valid=%b y=%h expected 1 0 00000000",
               bus_if.in_ready, bus_if.out_valid, bus_if.y);
    end
    for (int i = 0; i < 12; i++) begin
      if (bus_if.out_valid !== 1'b0) flagged = 1'b1;
      tick();
    end
    checks++;
    if (flagged !== 1'b0) begin
      errors++;
      $display("FAIL aborted_valid: out_valid raised after abort, expected none");
    end
    send(32'hc8110af6);
    wait_out_valid(n);
    checks++;
    if (bus_if.y !== 32'hed342fd3) begin
      errors++;
      $display("FAIL after_reset_y: got %h expected ed342fd3", bus_if.y);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec[16];
    int   i = 0;
    int   cyc = 0;
    int   first = -1;
    int   last = -1;
    int   out0;
    logic ir;
    for (int k = 0; k < 16; k++) vec[k] = $urandom;
    out0 = n_out;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.x         = vec[0];
    while (i < 16 && cyc < 1000) begin
      ir = bus_if.in_ready;
      tick();
      cyc++;
      if (ir) begin
        if (i == 0) first = cyc;
        last = cyc;
        i++;
        if (i < 16) bus_if.x = vec[i];
        else        bus_if.in_valid = 1'b0;
      end
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (i !== 16) begin
      errors++;
      $display("FAIL b2b_accepted: got %0d inputs expected 16", i);
    end
    checks++;
    if (last - first !== 15 * PERIOD) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles for 15 intervals expected %0d", last - first, 15 * PERIOD);
    end
    drain();
    checks++;
    if (n_out - out0 !== 16) begin
      errors++;
      $display("FAIL b2b_outputs: got %0d results expected 16", n_out - out0);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d results never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_rho

// File: doc/serial_rho.md
Name: serial_rho

Overview:
- Column-mixing linear layer ("rho") of the SWAN block-cipher datapath; operates on one half-block (SIDE_SIZE bits).
- Half-block = 4 columns of COLUMN_SIZE bits; each output column = XOR of the other three input columns.
- Serial implementation processes one column per clock, trading latency for a single COLUMN_SIZE-wide XOR datapath.
- Sits between the theta (nonlinear) stage and key addition in the round pipeline.

Parameters:
- BLOCK_SIZE, 64, cipher block width in bits; must be a multiple of 8.
- SIDE_SIZE, BLOCK_SIZE/2, derived localparam, half-block width processed.
- COLUMN_SIZE, SIDE_SIZE/4, derived localparam, column width (8 at default).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  x is valid.
- in_ready  output  1  block can accept x.
- x  input  [0:SIDE_SIZE-1]  input half-block; bit 0 = MSB; column c = x[c*COLUMN_SIZE : c*COLUMN_SIZE+COLUMN_SIZE-1].
- out_valid  output  1  y holds a finished result.
- out_ready  input  1  consumer accepts y.
- y  output  [0:SIDE_SIZE-1]  result, same column layout as x.

Behaviour:
- Function: P = x0^x1^x2^x3 (column-wise); y_c = x_c ^ P, equivalently y0=x1^x2^x3, y1=x0^x2^x3, y2=x0^x1^x3, y3=x0^x1^x2. The map is an involution.
- States: IDLE, ACCUM, APPLY, DONE. 2-bit column counter col.
- Reset: state=IDLE, col=0, P=0, y=0, out_valid=0; in_ready=1 once reset deasserts. Reset asserted mid-operation aborts the operation; no partial result is ever flagged valid.
- IDLE: in_ready=1. On in_valid at a clock edge, register x internally, clear P, col=0, go to ACCUM. x is sampled only at that edge.
- ACCUM: one cycle per column; P ^= x_col; col increments; after col 3, col wraps to 0 and state goes to APPLY (4 cycles).
- APPLY: one cycle per column; y_col <= x_col ^ P; after col 3 go to DONE (4 cycles).
- DONE: out_valid=1. y is stable and holds while out_ready=0 (backpressure, no timeout). On out_ready, go to IDLE with out_valid=0.
- Latency: handshake at edge k gives out_valid=1 after edge k+8. If out_ready is held high, the next x is accepted at edge k+10.
- in_ready=0 in all states except IDLE. in_valid outside IDLE is ignored.
- y retains the last result after the out_ready handshake until the next APPLY overwrites it.
- In APPLY, y is updated one column at a time; consumers read y only while out_valid=1.

Optional Feature:
- RHO_PARALLEL_EN defined: ACCUM and APPLY are replaced by one combinational 4-column computation. Accept at edge k; y and out_valid are registered at edge k+1; the DONE handshake is unchanged.
- RHO_PARALLEL_EN undefined: serial 8-cycle behaviour as specified above.
- Function and ports are identical in both builds.

Decomposition:
- Shared package swan_pkg holds BLOCK_SIZE default, the SIDE_SIZE/COLUMN_SIZE derivations and the state enum typedef rho_state_t.
- One natural sub-module, rho_column_xor: combinational COLUMN_SIZE-wide two-input XOR. It is reused for accumulation and apply, and instantiated 4× under RHO_PARALLEL_EN.

Test Plan:
- x=0xc8110af6, out_ready=1 → y=0xed342fd3; out_valid rises exactly 8 edges after acceptance (1 edge with RHO_PARALLEL_EN).
- x=0xed342fd3 → y=0xc8110af6 (involution); x=0x00000000 → 0x00000000; x=0xffffffff → 0xffffffff.
- x=0x01000000 → y=0x00010101; x=0x000000ff → y=0xffffff00.
- Backpressure: hold out_ready=0 for 20 cycles; y and out_valid stay stable and in_ready=0; release out_ready, then in_ready=1 on the next cycle.
- Reset: assert rst in cycle 3 of ACCUM; state returns to IDLE, y=0, out_valid=0. The next x=0xc8110af6 still yields 0xed342fd3.
- Back-to-back: 16 random inputs with in_valid held high; each result matches the reference model, and no input is dropped or duplicated.
